// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// State encoding, parity modes and mid-bit arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } uart_rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int mid_of(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output starts at a known level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Capture the raw input, then re-register it to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_byte_rx.sv
// Serial-to-byte UART receiver with 2-of-3 mid-bit voting.
// Delivers 8N1/8E1/8O1 bytes; framing and parity errors are flagged, not delivered.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = PAR_NONE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iRx,
    output logic       oDv,
    output logic [7:0] oByte,
    output logic       oFrameErr,
    output logic       oParityErr,
    output logic       oBusy
);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks
        $error("uart_byte_rx: CLKS_PER_BIT must be >= 8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
        $error("uart_byte_rx: PARITY must be 0, 1 or 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int MID = mid_of(CLKS_PER_BIT);
    localparam logic [CW-1:0] START_LAST = CW'(MID + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic          ODD_PAR    = (PARITY == PAR_ODD);

    uart_rx_state_t r_state, w_state_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic           r_v0, w_v0_nx;
    logic           r_v1, w_v1_nx;
    logic [7:0]     r_shreg, w_shreg_nx;
    logic [2:0]     r_idx, w_idx_nx;
    logic           r_perr, w_perr_nx;
    logic [7:0]     r_byte, w_byte_nx;
    logic           r_dv, w_dv_nx;
    logic           r_ferr, w_ferr_nx;
    logic           r_pstb, w_pstb_nx;

    logic           w_rx_s;
    logic           r_rx_d;
    logic [1:0]     r_warm;
    logic           r_armed;

    logic [CW-1:0]  w_last;
    logic           w_at_s0;
    logic           w_at_s1;
    logic           w_at_dec;
    logic           w_vote;
    logic           w_fall;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (iRx),
        .o_q   (w_rx_s)
    );

    // Edge history; arm start detection only once the synchroniser
    // reflects the real line and that line has been seen high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d  <= 1'b1;
            r_warm  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            r_rx_d <= w_rx_s;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end else if (w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // START votes around its own mid-point; later bits vote one bit period on
    assign w_last   = (r_state == START) ? START_LAST : BIT_LAST;
    assign w_at_s0  = (r_cnt == w_last - CW'(2));
    assign w_at_s1  = (r_cnt == w_last - CW'(1));
    assign w_at_dec = (r_cnt == w_last);
    assign w_vote   = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
    assign w_fall   = r_armed & r_rx_d & ~w_rx_s;

    // Next-state, datapath and strobe decode
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CW'(1);
        w_v0_nx    = w_at_s0 ? w_rx_s : r_v0;
        w_v1_nx    = w_at_s1 ? w_rx_s : r_v1;
        w_shreg_nx = r_shreg;
        w_idx_nx   = r_idx;
        w_perr_nx  = r_perr;
        w_byte_nx  = r_byte;
        w_dv_nx    = 1'b0;
        w_ferr_nx  = 1'b0;
        w_pstb_nx  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx  = '0;
                w_idx_nx  = '0;
                w_perr_nx = 1'b0;
                if (w_fall) begin
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_at_dec) begin
                    w_cnt_nx   = '0;
                    w_state_nx = w_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_at_dec) begin
                    w_cnt_nx   = '0;
                    w_shreg_nx = {w_vote, r_shreg[7:1]};
                    w_idx_nx   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (w_at_dec) begin
                    w_cnt_nx   = '0;
                    w_perr_nx  = ((^r_shreg) ^ w_vote) != ODD_PAR;
                    w_state_nx = STOP;
                end
            end
            STOP: begin
                if (w_at_dec) begin
                    w_cnt_nx = '0;
                    if (!w_vote) begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = BRK;
                    end else if (r_perr) begin
                        w_pstb_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_byte_nx  = r_shreg;
                        w_dv_nx    = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
            end
            BRK: begin
                w_cnt_nx = '0;
                if (w_rx_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, counter, shifter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
            r_shreg <= 8'h00;
            r_idx   <= 3'd0;
            r_perr  <= 1'b0;
            r_byte  <= 8'h00;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
            r_pstb  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_v0    <= w_v0_nx;
            r_v1    <= w_v1_nx;
            r_shreg <= w_shreg_nx;
            r_idx   <= w_idx_nx;
            r_perr  <= w_perr_nx;
            r_byte  <= w_byte_nx;
            r_dv    <= w_dv_nx;
            r_ferr  <= w_ferr_nx;
            r_pstb  <= w_pstb_nx;
        end
    end

    assign oDv        = r_dv;
    assign oByte      = r_byte;
    assign oFrameErr  = r_ferr;
    assign oParityErr = r_pstb;
    assign oBusy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit.
// One receiver without parity, one with even parity.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam real BT = 160.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       dv0, fe0, pe0, busy0;
    logic       dv1, fe1, pe1, busy1;
    logic [7:0] byte0, byte1;

    int total = 0;
    int bad = 0;
    int dv_n[2] = '{0, 0};
    int fe_n[2] = '{0, 0};
    int pe_n[2] = '{0, 0};
    int busy_seen[2] = '{0, 0};
    int excl_bad = 0;
    logic [7:0] log0[$];

    typedef struct {
        int         dev;
        logic [7:0] data;
        int         par;
        logic       stop;
        real        bt;
        int         e_dv;
        int         e_fe;
        int         e_pe;
        logic [7:0] e_byte;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_byte_rx #(.CLKS_PER_BIT(16), .PARITY(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .iRx        (rx0),
        .oDv        (dv0),
        .oByte      (byte0),
        .oFrameErr  (fe0),
        .oParityErr (pe0),
        .oBusy      (busy0)
    );

    uart_byte_rx #(.CLKS_PER_BIT(16), .PARITY(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .iRx        (rx1),
        .oDv        (dv1),
        .oByte      (byte1),
        .oFrameErr  (fe1),
        .oParityErr (pe1),
        .oBusy      (busy1)
    );

    // Strobe and busy monitor, sampled away from the rising edge
    always @(negedge clk) begin
        if (dv0) begin
            dv_n[0]++;
            log0.push_back(byte0);
        end
        if (fe0) fe_n[0]++;
        if (pe0) pe_n[0]++;
        if (dv1) dv_n[1]++;
        if (fe1) fe_n[1]++;
        if (pe1) pe_n[1]++;
        if (busy0) busy_seen[0] = 1;
        if (busy1) busy_seen[1] = 1;
        if (int'(dv0) + int'(fe0) + int'(pe0) > 1) excl_bad++;
        if (int'(dv1) + int'(fe1) + int'(pe1) > 1) excl_bad++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int dev, input logic v);
        if (dev == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic send(input int dev, input logic [7:0] d, input int par,
                        input logic stop, input real bt);
        set_line(dev, 1'b0);
        #(bt);
        for (int i = 0; i < 8; i++) begin
            set_line(dev, d[i]);
            #(bt);
        end
        if (par >= 0) begin
            set_line(dev, par != 0);
            #(bt);
        end
        set_line(dev, stop);
        #(bt);
        if (stop) set_line(dev, 1'b1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int d_dv, d_fe, d_pe, n0;
        vecs[0] = '{0, 8'hA5, -1, 1'b1, BT,    1, 0, 0, 8'hA5};
        vecs[1] = '{0, 8'hA5, -1, 1'b1, 164.8, 1, 0, 0, 8'hA5};
        vecs[2] = '{0, 8'hA5, -1, 1'b1, 155.2, 1, 0, 0, 8'hA5};
        vecs[3] = '{0, 8'h81, -1, 1'b1, BT,    1, 0, 0, 8'h81};
        vecs[4] = '{1, 8'h07,  1, 1'b1, BT,    1, 0, 0, 8'h07};
        vecs[5] = '{1, 8'h07,  0, 1'b1, BT,    0, 0, 1, 8'h07};
        vecs[6] = '{1, 8'h5A,  0, 1'b1, BT,    1, 0, 0, 8'h5A};
        vecs[7] = '{1, 8'h5A,  1, 1'b1, BT,    0, 0, 1, 8'h5A};

        #52;
        chk("rst_dv", int'(dv0), 0);
        chk("rst_fe", int'(fe0), 0);
        chk("rst_pe", int'(pe0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_byte", int'(byte0), 8'h00);
        chk("rst_byte_p", int'(byte1), 8'h00);
        #48;
        rst_n = 1'b1;
        cycles(10);

        for (int v = 0; v < 8; v++) begin
            int dv_b, fe_b, pe_b, dev;
            dev = vecs[v].dev;
            dv_b = dv_n[dev];
            fe_b = fe_n[dev];
            pe_b = pe_n[dev];
            send(dev, vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].bt);
            cycles(8);
            chk($sformatf("v%0d_dv", v), dv_n[dev] - dv_b, vecs[v].e_dv);
            chk($sformatf("v%0d_fe", v), fe_n[dev] - fe_b, vecs[v].e_fe);
            chk($sformatf("v%0d_pe", v), pe_n[dev] - pe_b, vecs[v].e_pe);
            chk($sformatf("v%0d_byte", v),
                int'(dev == 0 ? byte0 : byte1), int'(vecs[v].e_byte));
            chk($sformatf("v%0d_busy", v),
                int'(dev == 0 ? busy0 : busy1), 0);
            cycles(4);
        end

        // back-to-back frames with a single stop bit
        n0 = log0.size();
        send(0, 8'h00, -1, 1'b1, BT);
        send(0, 8'hFF, -1, 1'b1, BT);
        cycles(8);
        chk("b2b_count", log0.size() - n0, 2);
        if (log0.size() >= n0 + 2) begin
            chk("b2b_first", int'(log0[n0]), 8'h00);
            chk("b2b_second", int'(log0[n0 + 1]), 8'hFF);
        end

        // short low glitch on an idle line
        cycles(10);
        busy_seen[0] = 0;
        d_dv = dv_n[0]; d_fe = fe_n[0]; d_pe = pe_n[0];
        rx0 = 1'b0;
        #50;
        rx0 = 1'b1;
        cycles(40);
        chk("glitch_busy_seen", busy_seen[0], 1);
        chk("glitch_strobes",
            (dv_n[0] - d_dv) + (fe_n[0] - d_fe) + (pe_n[0] - d_pe), 0);
        chk("glitch_idle", int'(busy0), 0);

        // framing error followed by a long break
        d_dv = dv_n[0]; d_fe = fe_n[0]; d_pe = pe_n[0];
        send(0, 8'h3C, -1, 1'b0, BT);
        #(40.0 * BT);
        chk("brk_busy", int'(busy0), 1);
        chk("ferr_count", fe_n[0] - d_fe, 1);
        chk("ferr_no_dv", dv_n[0] - d_dv, 0);
        chk("ferr_no_pe", pe_n[0] - d_pe, 0);
        chk("ferr_byte_kept", int'(byte0), 8'hFF);
        rx0 = 1'b1;
        cycles(20);
        chk("brk_exit", int'(busy0), 0);
        d_dv = dv_n[0];
        send(0, 8'h12, -1, 1'b1, BT);
        cycles(8);
        chk("after_brk_dv", dv_n[0] - d_dv, 1);
        chk("after_brk_byte", int'(byte0), 8'h12);
        chk("after_brk_fe", fe_n[0] - d_fe, 1);

        // reset during bit 4 of 0x55
        cycles(10);
        d_dv = dv_n[0]; d_fe = fe_n[0]; d_pe = pe_n[0];
        rx0 = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx0 = (i % 2 == 0);
            #(BT);
        end
        rx0 = 1'b1;
        #(BT / 2.0);
        rst_n = 1'b0;
        #33;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_byte", int'(byte0), 8'h00);
        rst_n = 1'b1;
        #(12.0 * BT);
        chk("midrst_strobes",
            (dv_n[0] - d_dv) + (fe_n[0] - d_fe) + (pe_n[0] - d_pe), 0);
        send(0, 8'hC3, -1, 1'b1, BT);
        cycles(8);
        chk("midrst_next_dv", dv_n[0] - d_dv, 1);
        chk("midrst_next_byte", int'(byte0), 8'hC3);

        // line held low across reset release is not a start
        cycles(10);
        rx0 = 1'b0;
        #40;
        rst_n = 1'b0;
        #47;
        rst_n = 1'b1;
        busy_seen[0] = 0;
        d_dv = dv_n[0]; d_fe = fe_n[0]; d_pe = pe_n[0];
        cycles(300);
        rx0 = 1'b1;
        cycles(40);
        chk("low_rel_busy", busy_seen[0], 0);
        chk("low_rel_strobes",
            (dv_n[0] - d_dv) + (fe_n[0] - d_fe) + (pe_n[0] - d_pe), 0);
        send(0, 8'h5A, -1, 1'b1, BT);
        cycles(8);
        chk("low_rel_next_byte", int'(byte0), 8'h5A);

        chk("strobes_exclusive", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
